blockmem_ctrl: RTL and testbench

Block-transfer memory controller sitting directly downstream of the data cache: it serves whole-line fills (read) and dirty-line evictions (write) over a valid/ready request port and a one-cycle response pulse. It replaces the cache's zero-time backing-memory access with a realistic multi-cycle transaction: fixed access latency, then one word moved per cycle between the request block register and word-wide storage. One transaction is outstanding at a time, served strictly in order; the cache issues eviction-then-fill as two back-to-back requests.

---
 rtl/blockmem_ctrl_pkg.sv | 11 +
 rtl/blockmem_array.sv | 17 +
 rtl/blockmem_ctrl.sv | 85 ++++++++
 tb/tb_blockmem_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/blockmem_ctrl_pkg.sv
// blockmem_ctrl_pkg: shared geometry, latency and FSM state encoding for the block-transfer memory controller
package blockmem_ctrl_pkg;
  localparam int WORD_SIZE = 32;
  localparam int BYTE_SIZE = 8;
  localparam int BLOCK_WORDS = 8;
  localparam int BLOCK_SIZE = WORD_SIZE * BLOCK_WORDS;
  localparam int CACHE_OFFSET_LEN = $clog2(BLOCK_SIZE / BYTE_SIZE);
  localparam int MEM_LATENCY = 4;
  localparam int MEM_DEPTH_BLOCKS = 256;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_RESP} state_t;
endpackage

// File: rtl/blockmem_array.sv
// blockmem_array: word-wide single-port storage (clk, we, addr, wdata -> rdata), combinational read, write on rising edge
module blockmem_array #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH = 2048,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);
  logic [WORD_SIZE-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/blockmem_ctrl.sv
// blockmem_ctrl: whole-line fill/evict controller (clk, rst, req_valid/ready/write/addr/wdata -> resp_valid/rdata, busy) with fixed latency then one word per cycle
module blockmem_ctrl #(
  parameter int WORD_SIZE = blockmem_ctrl_pkg::WORD_SIZE,
  parameter int BLOCK_WORDS = blockmem_ctrl_pkg::BLOCK_WORDS,
  parameter int DEPTH_BLOCKS = blockmem_ctrl_pkg::MEM_DEPTH_BLOCKS,
  parameter int LATENCY = blockmem_ctrl_pkg::MEM_LATENCY
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [31:0]                    req_addr,
  input  logic [BLOCK_WORDS*WORD_SIZE-1:0] req_wdata,
  output logic                           resp_valid,
  output logic [BLOCK_WORDS*WORD_SIZE-1:0] resp_rdata,
  output logic                           busy
);
  import blockmem_ctrl_pkg::*;
  localparam int IDX_W = $clog2(DEPTH_BLOCKS);
  localparam int BEAT_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W = $clog2(BLOCK_WORDS * WORD_SIZE / 8);
  localparam int CNT_W = $clog2(LATENCY + 1);
  state_t state;
  logic wr;
  logic [IDX_W-1:0] idx;
  logic [BEAT_W-1:0] beat;
  logic [CNT_W-1:0] cnt;
  logic [BLOCK_WORDS-1:0][WORD_SIZE-1:0] line, line_nxt;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic mem_we;
  logic [BEAT_W-1:0] slot;
  logic unused;
  assign unused = ^{req_addr[31:OFF_W+IDX_W], req_addr[OFF_W-1:0]};
  assign req_ready = state == S_IDLE && !rst;
  assign busy = state != S_IDLE;
  assign resp_valid = state == S_RESP;
  // word 0 sits in the top bits of the line, so beat n maps to packed slot ~n
  assign slot = ~beat;
  // reset on a write beat suppresses that beat, leaving only the earlier words stored
  assign mem_we = state == S_XFER && wr && !rst;
  always_comb begin
    line_nxt = line;
    line_nxt[slot] = mem_rdata;
  end
  blockmem_array #(.WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH_BLOCKS * BLOCK_WORDS)) u_array (
    .clk(clk),
    .we(mem_we),
    .addr({idx, beat}),
    .wdata(line[slot]),
    .rdata(mem_rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      beat <= '0;
      cnt <= '0;
      resp_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          state <= S_WAIT;
          cnt <= '0;
          wr <= req_write;
          idx <= req_addr[OFF_W+IDX_W-1:OFF_W];
          line <= req_wdata;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          beat <= '0;
          if (cnt == CNT_W'(LATENCY - 1)) state <= S_XFER;
        end
        S_XFER: begin
          if (!wr) line <= line_nxt;
          beat <= beat + 1'b1;
          if (beat == BEAT_W'(BLOCK_WORDS - 1)) begin
            state <= S_RESP;
            if (!wr) resp_rdata <= line_nxt;
          end
        end
        S_RESP: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blockmem_ctrl.sv
// tb_blockmem_ctrl: directed and randomized line transfers checked against a transaction-level memory model
module tb_blockmem_ctrl;
  localparam int L = 4;
  localparam int W = 8;
  localparam int D = 256;
  logic clk = 0;
  logic rst = 1;
  logic req_valid = 0;
  logic req_write = 0;
  logic [31:0] req_addr = 0;
  logic [255:0] req_wdata = 0;
  logic req_ready, resp_valid, busy;
  logic [255:0] resp_rdata;
  int errors = 0;
  int checks = 0;
  logic [31:0] mm [D*W];
  bit act = 0;
  int age = 0;
  bit m_wr;
  int m_idx;
  logic [255:0] m_line;
  logic [255:0] exp_rdata = '0;
  int cyc = 0;
  int acc_cyc = -1;
  always #5 clk = ~clk;
  blockmem_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy)
  );
  function automatic logic [31:0] wsel(logic [255:0] l, int n);
    return l[255-32*n -: 32];
  endfunction
  task automatic chk(string name, logic [255:0] got, logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  initial begin
    for (int i = 0; i < D*W; i++) mm[i] = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        act = 0;
        exp_rdata = '0;
      end else if (act) begin
        age++;
        if (m_wr && age >= L+1 && age <= L+W) mm[m_idx*W + age-L-1] = wsel(m_line, age-L-1);
        if (!m_wr && age == L+W)
          for (int j = 0; j < W; j++) exp_rdata[255-32*j -: 32] = mm[m_idx*W + j];
        if (age == L+W+1) act = 0;
      end else if (req_valid) begin
        act = 1;
        age = 0;
        m_wr = req_write;
        m_idx = int'(req_addr[12:5]);
        m_line = req_wdata;
        acc_cyc = cyc;
      end
    end
  end
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("ready", {255'd0, req_ready}, {255'd0, !act && !rst});
      chk("busy", {255'd0, busy}, {255'd0, act});
      chk("resp_valid", {255'd0, resp_valid}, {255'd0, act && age == L+W});
      chk("resp_rdata", resp_rdata, exp_rdata);
    end
  end
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [255:0] data, output int acc);
    int n;
    n = 0;
    acc = -1;
    req_valid = 1;
    req_write = wr;
    req_addr = addr;
    req_wdata = data;
    while (1) begin
      @(posedge clk);
      #1;
      n++;
      if (acc_cyc == cyc) begin
        acc = acc_cyc;
        break;
      end
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout addr=%h", addr);
        break;
      end
    end
    #1;
    req_valid = 0;
    req_write = 1'($urandom);
    req_addr = $urandom;
    req_wdata = {8{$urandom}};
  endtask
  task automatic await_resp(output int lat, output logic [255:0] data);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!resp_valid && lat < 60);
    if (!resp_valid) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout got=%0d want<60", lat);
    end
    data = resp_rdata;
    #1;
  endtask
  task automatic pulse_end();
    @(posedge clk);
    #1;
    chk("pulse_width", {255'd0, resp_valid}, 256'd0);
    #1;
  endtask
  initial begin
    int a0, a1, lat, seen;
    logic [255:0] l, l2, l3, l4, d, ab;
    req_valid = 1;
    req_write = 1;
    req_addr = 32'h40;
    req_wdata = '1;
    repeat (3) begin
      @(posedge clk);
      #2;
      chk("rst_ready", {255'd0, req_ready}, 256'd0);
      chk("rst_resp", {255'd0, resp_valid}, 256'd0);
      chk("rst_busy", {255'd0, busy}, 256'd0);
      chk("rst_rdata", resp_rdata, 256'd0);
    end
    rst = 0;
    req_valid = 0;
    #1;
    chk("ready_after_rst", {255'd0, req_ready}, 256'd1);
    for (int n = 0; n < W; n++) l[255-32*n -: 32] = 32'(n + 1);
    do_req(1, 32'h0000_0040, l, a0);
    await_resp(lat, d);
    chk("wr_latency", 256'(lat), 256'd12);
    pulse_end();
    do_req(0, 32'h0000_0047, '0, a0);
    await_resp(lat, d);
    chk("rd_latency", 256'(lat), 256'd12);
    chk("rd_data", d, 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
    chk("rd_word0", 256'(d[255:224]), 256'd1);
    chk("rd_word7", 256'(d[31:0]), 256'd8);
    pulse_end();
    l2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_req(1, 32'h0000_2040, l2, a0);
    await_resp(lat, d);
    do_req(0, 32'h0000_0040, '0, a0);
    await_resp(lat, d);
    chk("alias_data", d, l2);
    l3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    l4 = ~l3;
    do_req(1, 32'h0000_0100, l3, a0);
    do_req(1, 32'h0000_0200, l4, a1);
    chk("bp_gap", 256'(a1 - a0), 256'd14);
    await_resp(lat, d);
    do_req(0, 32'h0000_0100, '0, a0);
    await_resp(lat, d);
    chk("bp_first_line", d, l3);
    do_req(0, 32'h0000_0200, '0, a0);
    await_resp(lat, d);
    chk("bp_second_line", d, l4);
    do_req(1, 32'(5 << 5), {8{32'hAAAAAAAA}}, a0);
    do_req(0, 32'(9 << 5), '0, a1);
    chk("ef_gap", 256'(a1 - a0), 256'd14);
    await_resp(lat, d);
    chk("ef_latency", 256'(lat), 256'd12);
    chk("ef_zero_line", d, 256'd0);
    @(posedge clk);
    #2;
    chk("ef_ready", {255'd0, req_ready}, 256'd1);
    do_req(1, 32'(20 << 5), '1, a0);
    repeat (7) @(posedge clk);
    #2;
    rst = 1;
    @(posedge clk);
    #2;
    rst = 0;
    chk("abort_idle", {255'd0, busy}, 256'd0);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      seen += int'(resp_valid);
      #1;
    end
    chk("abort_noresp", 256'(seen), 256'd0);
    do_req(0, 32'(20 << 5), '0, a0);
    await_resp(lat, d);
    ab = {{3{32'hFFFFFFFF}}, {5{32'h0}}};
    chk("abort_partial", d, ab);
    repeat (60) begin
      l = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_req(1'($urandom), ($urandom & 32'hFFFF_E01F) | 32'($urandom_range(16, 23) << 5), l, a0);
      repeat ($urandom_range(0, 16)) begin
        @(posedge clk);
        #2;
      end
    end
    repeat (20) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
